ef_pwm_deadtime: RTL

Complementary PWM driver with dead-time insertion, placed directly downstream of the timer's `pwm_out`. It converts a single-ended PWM stream into high-side and low-side gate signals. Break-before-make gaps are set independently for rising and falling transitions, and the two outputs are never asserted together. `pwm_in` is synchronous to `clk_i`, so the block has no input synchronizer on the PWM path.

---
 rtl/ef_pwm_deadtime.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ef_pwm_deadtime.sv
// ef_pwm_deadtime
// ---------------------------------------------------------------------------
// Complementary PWM driver with break-before-make dead-time insertion. The
// single-ended PWM stream from the timer is split into a high-side and a
// low-side gate drive. Rising and falling transitions each get their own
// programmable gap, and the two drives are never on together.
//
// Parameters:
//   DT_W        width of the dead-time counter and the dead-time inputs
//
// Ports:
//   clk_i       block clock, shared with the timer
//   rst_i       asynchronous, active-high reset
//   en          block enable; while low both drives are held low
//   pwm_in      PWM stream, already synchronous to clk_i
//   dt_rise     gap cycles inserted before pwm_h turns on
//   dt_fall     gap cycles inserted before pwm_l turns on
//   pwm_h       high-side drive (registered)
//   pwm_l       low-side drive (registered)
//   dt_active   high while a dead-time gap is running (registered)
//
// Optional fault shutdown, enabled by defining EF_PWM_DT_FAULT_EN:
//   fault_in    asynchronous fault level, 2-flop synchronized
//   fault_clr   single-cycle clear, honoured only once the fault has gone
//   fault_o     high while latched in the fault state (registered)
// ---------------------------------------------------------------------------

module ef_pwm_deadtime #(
    parameter int unsigned DT_W = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            en,
    input  logic            pwm_in,
    input  logic [DT_W-1:0] dt_rise,
    input  logic [DT_W-1:0] dt_fall,
`ifdef EF_PWM_DT_FAULT_EN
    input  logic            fault_in,
    input  logic            fault_clr,
    output logic            fault_o,
`endif
    output logic            pwm_h,
    output logic            pwm_l,
    output logic            dt_active
);

    // -----------------------------------------------------------------------
    // State encoding
    // -----------------------------------------------------------------------
`ifdef EF_PWM_DT_FAULT_EN
    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StLowOn  = 3'd1,
        StDtH    = 3'd2,
        StHighOn = 3'd3,
        StDtL    = 3'd4,
        StFault  = 3'd5
    } state_e;
`else
    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StLowOn  = 3'd1,
        StDtH    = 3'd2,
        StHighOn = 3'd3,
        StDtL    = 3'd4
    } state_e;
`endif

    state_e          state_q, state_d;
    logic [DT_W-1:0] cnt_q, cnt_d;
    logic            pwm_h_q, pwm_h_d;
    logic            pwm_l_q, pwm_l_d;
    logic            dt_active_q, dt_active_d;

    // Where a rising / falling request lands: straight into the on-state when
    // the dead time is zero, so the swap happens at a single edge.
    state_e          rise_target;
    state_e          fall_target;
    logic            dt_rise_zero;
    logic            dt_fall_zero;

    assign dt_rise_zero = (dt_rise == '0);
    assign dt_fall_zero = (dt_fall == '0);
    assign rise_target  = dt_rise_zero ? StHighOn : StDtH;
    assign fall_target  = dt_fall_zero ? StLowOn : StDtL;

    // Gap ends on the edge where the counter holds 1; the <= also covers a
    // counter that is somehow zero inside a gap so the FSM cannot stall.
    logic cnt_last;
    assign cnt_last = (cnt_q <= DT_W'(1));

    // -----------------------------------------------------------------------
    // Fault synchronizer (optional)
    // -----------------------------------------------------------------------
`ifdef EF_PWM_DT_FAULT_EN
    logic fault_meta_q, fault_meta_d;
    logic fault_sync_q, fault_sync_d;
    logic fault_o_q, fault_o_d;

    always_comb begin
        fault_meta_d = fault_in;
        fault_sync_d = fault_meta_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fault_meta_q <= 1'b0;
            fault_sync_q <= 1'b0;
        end else begin
            fault_meta_q <= fault_meta_d;
            fault_sync_q <= fault_sync_d;
        end
    end
`endif

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;

`ifdef EF_PWM_DT_FAULT_EN
        // Fault outranks enable and any PWM edge in the same cycle.
        if (fault_sync_q) begin
            state_d = StFault;
            cnt_d   = '0;
        end else if (state_q == StFault) begin
            if (fault_clr) begin
                state_d = StIdle;
            end
        end else
`endif
        if (!en) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (pwm_in) begin
                        state_d = rise_target;
                        cnt_d   = dt_rise;
                    end else begin
                        state_d = fall_target;
                        cnt_d   = dt_fall;
                    end
                end

                StLowOn: begin
                    if (pwm_in) begin
                        state_d = rise_target;
                        cnt_d   = dt_rise;
                    end
                end

                StDtH: begin
                    // A pulse shorter than the gap is swallowed.
                    if (!pwm_in) begin
                        state_d = StLowOn;
                        cnt_d   = '0;
                    end else if (cnt_last) begin
                        state_d = StHighOn;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - DT_W'(1);
                    end
                end

                StHighOn: begin
                    if (!pwm_in) begin
                        state_d = fall_target;
                        cnt_d   = dt_fall;
                    end
                end

                StDtL: begin
                    if (pwm_in) begin
                        state_d = StHighOn;
                        cnt_d   = '0;
                    end else if (cnt_last) begin
                        state_d = StLowOn;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - DT_W'(1);
                    end
                end

                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Output decode: registered from the next state so the drives change on
    // the same edge as the state and are glitch-free at the pins.
    // -----------------------------------------------------------------------
    always_comb begin
        pwm_h_d     = (state_d == StHighOn);
        pwm_l_d     = (state_d == StLowOn);
        dt_active_d = (state_d == StDtH) || (state_d == StDtL);
    end

`ifdef EF_PWM_DT_FAULT_EN
    always_comb begin
        fault_o_d = (state_d == StFault);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fault_o_q <= 1'b0;
        end else begin
            fault_o_q <= fault_o_d;
        end
    end

    assign fault_o = fault_o_q;
`endif

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            pwm_h_q     <= 1'b0;
            pwm_l_q     <= 1'b0;
            dt_active_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pwm_h_q     <= pwm_h_d;
            pwm_l_q     <= pwm_l_d;
            dt_active_q <= dt_active_d;
        end
    end

    assign pwm_h     = pwm_h_q;
    assign pwm_l     = pwm_l_q;
    assign dt_active = dt_active_q;

endmodule
